// File: rtl/div_unit.sv
// div_unit -- multi-cycle RV32M divider (DIV, DIVU, REM, REMU).
//
// Radix-2 restoring division over 32 iterations, one per cycle. The
// result comes back through a one-cycle write-back strobe (done/wb_en).
//
// Optional feature: define DIV_FAST_SPECIAL_EN to detect divide-by-zero
// and signed overflow at accept, so they complete one cycle later and do
// not iterate. Without it every operation runs all 32 iterations. The
// results are the same in both builds.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-low reset
//   start    request a division (sampled only in IDLE)
//   op       funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_val  dividend
//   rs2_val  divisor
//   rd_addr  destination register
//   kill     abort the in-flight operation (pipeline flush)
//   busy     high from the cycle after accept through DONE
//   done     one-cycle completion pulse
//   wb_en    register-file write enable (low when rd = 0)
//   wb_addr  register-file write address
//   result   quotient or remainder
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg;
  logic [XLEN-1:0] rem_reg;      // partial remainder; always < divisor
  logic [XLEN-1:0] quo_reg;      // dividend bits shift out the top, quotient bits in the bottom
  logic [XLEN-1:0] div_reg;      // |divisor|
  logic [5:0]      count_reg;
  logic            q_neg_reg;
  logic            r_neg_reg;
  logic            zero_reg;     // divisor was zero
  logic            is_rem_reg;
  logic [4:0]      rd_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            wb_en_reg;
  logic [4:0]      wb_addr_reg;
  logic [XLEN-1:0] result_reg;

  // Operand conditioning at accept. -x on XLEN bits maps 0x80000000 onto
  // itself, which is exactly the unsigned magnitude we want.
  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & rs1_val[XLEN-1];
    b_neg     = signed_op & rs2_val[XLEN-1];
    abs_a     = a_neg ? -rs1_val : rs1_val;
    abs_b     = b_neg ? -rs2_val : rs2_val;
  end

  // One restoring step: 33-bit shift-in and trial subtract.
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] final_val;

  always_comb begin
    rem_shift = {rem_reg, quo_reg[XLEN-1]};
    diff      = rem_shift - {1'b0, div_reg};
    rem_step  = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
    quo_step  = {quo_reg[XLEN-2:0], ~diff[XLEN]};
    // A zero divisor yields an all-ones quotient by itself; forcing it here
    // stops the sign fixup from flipping it for a negative dividend.
    if (zero_reg)
      q_fix = '1;
    else
      q_fix = q_neg_reg ? -quo_step : quo_step;
    r_fix     = r_neg_reg ? -rem_step : rem_step;
    final_val = is_rem_reg ? r_fix : q_fix;
  end

`ifdef DIV_FAST_SPECIAL_EN
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic            special_hit;
  logic [XLEN-1:0] special_val;

  always_comb begin
    special_hit = 1'b0;
    special_val = '0;
    if (rs2_val == '0) begin
      special_hit = 1'b1;
      special_val = op[1] ? rs1_val : '1;
    end else if (signed_op && rs1_val == INT_MIN && rs2_val == '1) begin
      special_hit = 1'b1;
      special_val = op[1] ? '0 : INT_MIN;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      rem_reg     <= '0;
      quo_reg     <= '0;
      div_reg     <= '0;
      count_reg   <= '0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      zero_reg    <= 1'b0;
      is_rem_reg  <= 1'b0;
      rd_reg      <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      wb_en_reg   <= 1'b0;
      wb_addr_reg <= '0;
      result_reg  <= '0;
    end else begin
      done_reg  <= 1'b0;
      wb_en_reg <= 1'b0;
      if (kill) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              is_rem_reg <= op[1];
              rd_reg     <= rd_addr;
              quo_reg    <= abs_a;
              div_reg    <= abs_b;
              rem_reg    <= '0;
              q_neg_reg  <= a_neg ^ b_neg;
              r_neg_reg  <= a_neg;
              zero_reg   <= (rs2_val == '0);
              count_reg  <= '0;
              busy_reg   <= 1'b1;
              state_reg  <= CALC;
`ifdef DIV_FAST_SPECIAL_EN
              if (special_hit) begin
                result_reg  <= special_val;
                wb_addr_reg <= rd_addr;
                done_reg    <= 1'b1;
                wb_en_reg   <= (rd_addr != 5'd0);
                state_reg   <= DONE;
              end
`endif
            end
          end
          CALC: begin
            rem_reg   <= rem_step;
            quo_reg   <= quo_step;
            count_reg <= count_reg + 6'd1;
            if (count_reg == 6'd31) begin
              // Outputs are registered on entry so they are valid throughout DONE.
              result_reg  <= final_val;
              wb_addr_reg <= rd_reg;
              done_reg    <= 1'b1;
              wb_en_reg   <= (rd_reg != 5'd0);
              state_reg   <= DONE;
            end
          end
          DONE: begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
          default: begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  // A flush arriving during DONE suppresses that cycle's write-back.
  assign busy    = busy_reg;
  assign done    = done_reg & ~kill;
  assign wb_en   = wb_en_reg & ~kill;
  assign wb_addr = wb_addr_reg;
  assign result  = result_reg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases, special cases,
// kill / reset / start-while-busy boundaries and random operations checked
// against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_addr;
  logic        kill;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  div_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_addr (rd_addr),
    .kill    (kill),
    .busy    (busy),
    .done    (done),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain arithmetic.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit is_rem;
    bit is_signed;
    int sa;
    int sb;
    is_rem    = o[1];
    is_signed = !o[0];
    sa = a;
    sb = b;
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return is_rem ? 32'd0 : 32'h8000_0000;
    if (is_signed) return is_rem ? sa % sb : sa / sb;
    return is_rem ? a % b : a / b;
  endfunction

  // Negedges after the accepting edge until done is visible.
  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_SPECIAL_EN
    return special ? 0 : 32;
`else
    return special ? 32 : 32;
`endif
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_addr = rd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp;
    int lat;
    int k;
    bit seen;
    exp = ref_model(o, a, b);
    lat = exp_latency(o, a, b);
    launch(o, a, b, rd);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    k = 0;
    seen = 0;
    while (!seen && k <= 40) begin
      if (done === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", k, lat);
    check("result", result, exp);
    check("wb_en", {31'd0, wb_en}, {31'd0, rd != 5'd0});
    check("wb_addr", {27'd0, wb_addr}, {27'd0, rd});
    check("busy_in_done", {31'd0, busy}, 32'd1);
    $display("op=%0d a=%h b=%h rd=%0d -> result=%h exp=%h lat=%0d", o, a, b, rd, result, exp, k);
    @(negedge clk);
    check("done_after", {31'd0, done}, 32'd0);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses;
    logic [31:0] captured;
    logic [1:0] ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0] rrd;

    rst = 1'b0; start = 1'b0; op = 2'd0; rs1_val = '0; rs2_val = '0; rd_addr = '0; kill = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wb_en", {31'd0, wb_en}, 32'd0);
    check("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b1;

    // Directed arithmetic and special cases.
    run_op(2'b01, 32'd100, 32'd7, 5'd5);
    run_op(2'b11, 32'd100, 32'd7, 5'd6);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd8);
    run_op(2'b00, 32'd5, 32'd0, 5'd9);
    run_op(2'b10, 32'd5, 32'd0, 5'd10);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd0, 5'd11);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 5'd12);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
    run_op(2'b01, 32'd100, 32'd7, 5'd0);

    // Kill mid-CALC: accept at T, kill sampled at T+10.
    launch(2'b01, 32'd100, 32'd7, 5'd3);
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || wb_en === 1'b1) pulses++;
      @(negedge clk);
    end
    check("kill_no_done", pulses, 0);
    run_op(2'b01, 32'd1000, 32'd9, 5'd4);

    // Start while busy is ignored.
    launch(2'b01, 32'd100, 32'd7, 5'd5);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b11; rs1_val = 32'd55; rs2_val = 32'd4; rd_addr = 5'd9;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    captured = '0;
    for (int i = 0; i < 45; i++) begin
      if (done === 1'b1) begin
        pulses++;
        captured = result;
      end
      @(negedge clk);
    end
    check("busy_start_one_done", pulses, 1);
    check("busy_start_result", captured, 32'd14);

    // Kill during DONE gates that cycle's strobes.
    launch(2'b01, 32'd100, 32'd7, 5'd2);
    repeat (32) @(negedge clk);
    check("pre_kill_done", {31'd0, done}, 32'd1);
    kill = 1'b1;
    #1;
    check("kill_done_gated", {31'd0, done}, 32'd0);
    check("kill_wb_en_gated", {31'd0, wb_en}, 32'd0);
    @(negedge clk);
    kill = 1'b0;

    // Reset mid-CALC.
    launch(2'b00, 32'd12345, 32'd11, 5'd17);
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_wb_en", {31'd0, wb_en}, 32'd0);
    check("mid_rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("mid_rst_no_done", pulses, 0);
    run_op(2'b00, 32'd12345, 32'd11, 5'd17);

    // Random operations.
    for (int n = 0; n < 40; n++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = pick_operand();
      rb  = pick_operand();
      rrd = 5'($urandom_range(0, 31));
      run_op(ro, ra, rb, rrd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
